// File: rtl/controler_intersectie_if.sv
// Bundle between the intersection phase sequencer and the light modules it drives.
// The master modport is the sequencer side; the slave modport is the light-module/stimulus side.
interface controler_intersectie_if;
  logic       clk_div;
  logic       clk_div_int;
  logic       ready_S;
  logic       ready_E;
  logic       ready_V;
  logic       ready_N;
  logic       ready_P;
  logic       buton_pieton;
  logic [2:0] stare_semafor;
  logic       cerere_pieton;
  logic       eroare;

  modport master (
    input  clk_div,
    input  clk_div_int,
    input  ready_S,
    input  ready_E,
    input  ready_V,
    input  ready_N,
    input  ready_P,
    input  buton_pieton,
    output stare_semafor,
    output cerere_pieton,
    output eroare
  );

  modport slave (
    output clk_div,
    output clk_div_int,
    output ready_S,
    output ready_E,
    output ready_V,
    output ready_N,
    output ready_P,
    output buton_pieton,
    input  stare_semafor,
    input  cerere_pieton,
    input  eroare
  );
endinterface

// File: rtl/controler_intersectie.sv
// Phase sequencer for the intersection: all-red clearance, closed-loop ready handshake,
// latched pedestrian request and a sticky watchdog fault.
module controler_intersectie #(
  parameter int T_CLEAR   = 2,
  parameter int T_TIMEOUT = 60
) (
  input  logic                   clk,
  input  logic                   rst,
  controler_intersectie_if.master bus
);

  localparam int CW = $clog2(T_CLEAR + 1);
  localparam int WW = $clog2(T_TIMEOUT + 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(T_CLEAR - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(T_TIMEOUT - 1);

  localparam logic [2:0] PH_ALLRED = 3'd0;
  localparam logic [2:0] PH_S      = 3'd1;
  localparam logic [2:0] PH_E      = 3'd2;
  localparam logic [2:0] PH_V      = 3'd3;
  localparam logic [2:0] PH_N      = 3'd4;
  localparam logic [2:0] PH_P      = 3'd5;
  localparam logic [2:0] PH_FLASH  = 3'd7;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    phase_reg, phase_next;
  logic [2:0]    phase_succ;
  logic [CW-1:0] clr_cnt_reg, clr_cnt_next;
  logic [WW-1:0] wd_cnt_reg, wd_cnt_next;
  logic [2:0]    stare_reg, stare_next;
  logic          eroare_reg, eroare_next;
  logic          req_reg, req_next;

  logic clk_div_q_reg;
  logic clk_div_int_q_reg;
  logic btn_meta_reg;
  logic btn_sync_reg;
  logic sample_reg;

  logic tick;
  logic strobe;
  logic ready_cur;
  logic wd_expire;
  logic pick_ped;
  logic req_set;

  // Edge detectors for the divided clocks, both sampled in the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_div_q_reg     <= 1'b0;
      clk_div_int_q_reg <= 1'b0;
    end else begin
      clk_div_q_reg     <= bus.clk_div;
      clk_div_int_q_reg <= bus.clk_div_int;
    end
  end

  assign tick   = bus.clk_div & ~clk_div_q_reg;
  assign strobe = bus.clk_div_int & ~clk_div_int_q_reg;

  // Push-button: 2-flop synchroniser, then one sample per strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_reg <= 1'b0;
      btn_sync_reg <= 1'b0;
      sample_reg   <= 1'b0;
    end else begin
      btn_meta_reg <= bus.buton_pieton;
      btn_sync_reg <= btn_meta_reg;
      if (strobe) begin
        sample_reg <= btn_sync_reg;
      end
    end
  end

  assign req_set = strobe & btn_sync_reg & sample_reg;

  // Only the module owning the current phase is listened to.
  always_comb begin
    ready_cur = 1'b0;
    case (phase_reg)
      PH_S:    ready_cur = bus.ready_S;
      PH_E:    ready_cur = bus.ready_E;
      PH_V:    ready_cur = bus.ready_V;
      PH_N:    ready_cur = bus.ready_N;
      PH_P:    ready_cur = bus.ready_P;
      default: ready_cur = 1'b0;
    endcase
  end

  always_comb begin
    phase_succ = PH_S;
    case (phase_reg)
      PH_S:    phase_succ = PH_E;
      PH_E:    phase_succ = PH_V;
      PH_V:    phase_succ = PH_N;
      PH_N:    phase_succ = req_reg ? PH_P : PH_S;
      default: phase_succ = PH_S;
    endcase
  end

  assign wd_expire = tick && (wd_cnt_reg == WD_LAST);

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    clr_cnt_next = clr_cnt_reg;
    wd_cnt_next  = wd_cnt_reg;
    pick_ped     = 1'b0;

    case (state_reg)
      CLEAR: begin
        if (tick) begin
          if (clr_cnt_reg == CLR_LAST) begin
            state_next   = ARM;
            phase_next   = phase_succ;
            clr_cnt_next = '0;
            wd_cnt_next  = '0;
            pick_ped     = (phase_succ == PH_P);
          end else begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
          end
        end
      end

      ARM: begin
        // Expiry is checked before the handshake so a tie always faults.
        if (wd_expire) begin
          state_next = FAULT;
        end else begin
          if (tick && (wd_cnt_reg < WD_LAST)) begin
            wd_cnt_next = wd_cnt_reg + 1'b1;
          end
          if (!ready_cur) begin
            state_next = RUN;
          end
        end
      end

      RUN: begin
        if (wd_expire) begin
          state_next = FAULT;
        end else begin
          if (tick && (wd_cnt_reg < WD_LAST)) begin
            wd_cnt_next = wd_cnt_reg + 1'b1;
          end
          if (ready_cur) begin
            state_next   = CLEAR;
            clr_cnt_next = '0;
          end
        end
      end

      default: begin
        state_next = FAULT;
      end
    endcase
  end

  // Outputs are registered from the next state so they move one clk after the decision.
  always_comb begin
    stare_next  = PH_ALLRED;
    eroare_next = 1'b0;
    case (state_next)
      CLEAR:   stare_next = PH_ALLRED;
      ARM,
      RUN:     stare_next = phase_next;
      default: begin
        stare_next  = PH_FLASH;
        eroare_next = 1'b1;
      end
    endcase
  end

  // A new press in the same cycle P is selected keeps the request for the next round.
  always_comb begin
    req_next = req_reg;
    if (req_set) begin
      req_next = 1'b1;
    end else if (pick_ped) begin
      req_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= CLEAR;
      phase_reg   <= PH_N;
      clr_cnt_reg <= '0;
      wd_cnt_reg  <= '0;
      stare_reg   <= PH_ALLRED;
      eroare_reg  <= 1'b0;
      req_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      clr_cnt_reg <= clr_cnt_next;
      wd_cnt_reg  <= wd_cnt_next;
      stare_reg   <= stare_next;
      eroare_reg  <= eroare_next;
      req_reg     <= req_next;
    end
  end

  assign bus.stare_semafor = stare_reg;
  assign bus.cerere_pieton = req_reg;
  assign bus.eroare        = eroare_reg;

endmodule

// File: tb/tb_controler_intersectie.sv
// Bench for controler_intersectie: randomized handshakes, button presses and bystander
// ready noise, checked against a phase-rotation model of the intersection.
module tb_controler_intersectie;

  localparam int T_CLEAR   = 2;
  localparam int T_TIMEOUT = 60;
  localparam int TICK_P    = 10;
  localparam int INT_P     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controler_intersectie_if bus();

  controler_intersectie #(
    .T_CLEAR  (T_CLEAR),
    .T_TIMEOUT(T_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         cyc;
  int         n_checks;
  int         n_pass;
  logic       div_prev;
  bit         tick_now;
  logic [2:0] cur_sel;
  logic [2:0] exp_phase;
  bit         exp_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
  endtask

  function automatic logic [2:0] next_phase(input logic [2:0] p, input bit req);
    if (p == 3'd4) return req ? 3'd5 : 3'd1;
    if (p == 3'd5) return 3'd1;
    return p + 3'd1;
  endfunction

  task automatic set_ready(input logic [2:0] p, input logic v);
    case (p)
      3'd1: bus.ready_S = v;
      3'd2: bus.ready_E = v;
      3'd3: bus.ready_V = v;
      3'd4: bus.ready_N = v;
      3'd5: bus.ready_P = v;
      default: ;
    endcase
  endtask

  // One clk: divided clocks follow the cycle count, non-owning readies get random noise.
  task automatic step();
    @(negedge clk);
    bus.clk_div     = ((cyc % TICK_P) < (TICK_P / 2));
    bus.clk_div_int = ((cyc % INT_P) < (INT_P / 2));
    if (cur_sel != 3'd1) bus.ready_S = 1'($urandom_range(0, 1));
    if (cur_sel != 3'd2) bus.ready_E = 1'($urandom_range(0, 1));
    if (cur_sel != 3'd3) bus.ready_V = 1'($urandom_range(0, 1));
    if (cur_sel != 3'd4) bus.ready_N = 1'($urandom_range(0, 1));
    if (cur_sel != 3'd5) bus.ready_P = 1'($urandom_range(0, 1));
    @(posedge clk);
    if (rst) begin
      tick_now = 1'b0;
      div_prev = 1'b0;
    end else begin
      tick_now = bus.clk_div && !div_prev;
      div_prev = bus.clk_div;
    end
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Clearance: the selected phase appears exactly on the T_CLEAR-th tick seen while all-red.
  task automatic run_clear(input logic [2:0] expv);
    int         cnt;
    logic [2:0] pre;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      pre = bus.stare_semafor;
      step();
      if (tick_now && pre == 3'd0) cnt++;
      if (bus.stare_semafor != 3'd0) break;
    end
    if (expv == 3'd5) exp_req = 1'b0;
    chk("clear_ticks", cnt, T_CLEAR);
    chk("phase_sel", bus.stare_semafor, expv);
    chk("req_at_sel", bus.cerere_pieton, exp_req);
    $display("select phase %0d after %0d clearance ticks, request=%0d", bus.stare_semafor, cnt, bus.cerere_pieton);
  endtask

  // Handshake: stale high holds, low arms, high completes and drops to all-red.
  task automatic do_phase(input logic [2:0] p);
    int hold;
    int low;
    hold = $urandom_range(1, 15);
    low  = $urandom_range(1, 25);
    set_ready(p, 1'b1);
    steps(hold);
    chk("arm_hold", bus.stare_semafor, p);
    set_ready(p, 1'b0);
    steps(low);
    chk("run_hold", bus.stare_semafor, p);
    set_ready(p, 1'b1);
    step();
    chk("done_allred", bus.stare_semafor, 3'd0);
    $display("phase %0d handshake: hold=%0d low=%0d -> state %0d", p, hold, low, bus.stare_semafor);
  endtask

  task automatic advance();
    logic [2:0] nxt;
    do_phase(exp_phase);
    nxt     = next_phase(exp_phase, exp_req);
    cur_sel = nxt;
    set_ready(nxt, 1'b1);
    run_clear(nxt);
    exp_phase = nxt;
  endtask

  task automatic press(input int len);
    bus.buton_pieton = 1'b1;
    steps(len);
    bus.buton_pieton = 1'b0;
    steps(8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(3);
    rst = 1'b0;
    exp_phase = 3'd4;
    exp_req   = 1'b0;
    cur_sel   = 3'd1;
    bus.ready_S = 1'b1;
  endtask

  initial begin
    int         wd;
    int         len;
    bit         will_tick;
    logic [2:0] pre;

    cyc = 0; n_checks = 0; n_pass = 0;
    div_prev = 1'b0; tick_now = 1'b0;
    cur_sel = 3'd1; exp_phase = 3'd4; exp_req = 1'b0;
    bus.clk_div = 1'b0; bus.clk_div_int = 1'b0; bus.buton_pieton = 1'b0;
    bus.ready_S = 1'b1; bus.ready_E = 1'b1; bus.ready_V = 1'b1;
    bus.ready_N = 1'b1; bus.ready_P = 1'b1;
    rst = 1'b1;

    // Reset state and first phase.
    steps(3);
    chk("rst_stare", bus.stare_semafor, 3'd0);
    chk("rst_req", bus.cerere_pieton, 1'b0);
    chk("rst_err", bus.eroare, 1'b0);
    rst = 1'b0;
    run_clear(3'd1);
    exp_phase = 3'd1;
    steps(3 * TICK_P);
    chk("stale_ready_S", bus.stare_semafor, 3'd1);

    // Full rotation without a request.
    for (int i = 0; i < 4; i++) advance();
    chk("rot_err", bus.eroare, 1'b0);
    chk("rot_back_to_S", exp_phase, 3'd1);

    // Glitch in S must not latch; a long press in E must.
    press(4);
    chk("glitch_no_req", bus.cerere_pieton, 1'b0);
    advance();
    len = $urandom_range(12, 20);
    press(len);
    exp_req = 1'b1;
    chk("press_req", bus.cerere_pieton, exp_req);
    $display("button press %0d clks -> request=%0d", len, bus.cerere_pieton);
    advance();
    advance();
    advance();
    chk("ped_phase", exp_phase, 3'd5);
    advance();
    chk("after_ped_S", exp_phase, 3'd1);

    // Bring N up with a pending request, then reset mid-RUN.
    advance();
    advance();
    press($urandom_range(12, 20));
    exp_req = 1'b1;
    chk("press_req2", bus.cerere_pieton, 1'b1);
    advance();
    bus.ready_N = 1'b0;
    steps(5);
    chk("n_run", bus.stare_semafor, 3'd4);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_stare", bus.stare_semafor, 3'd0);
    chk("async_rst_req", bus.cerere_pieton, 1'b0);
    $display("async reset in RUN of N -> state %0d request %0d", bus.stare_semafor, bus.cerere_pieton);
    steps(2);
    rst = 1'b0;
    exp_phase = 3'd4; exp_req = 1'b0; cur_sel = 3'd1; bus.ready_S = 1'b1;
    run_clear(3'd1);
    exp_phase = 3'd1;

    // Watchdog expiry on the same tick the handshake completes: fault wins.
    bus.ready_S = 1'b0;
    wd = 0;
    for (int i = 0; i < 2000; i++) begin
      pre = bus.stare_semafor;
      will_tick = ((cyc % TICK_P) < (TICK_P / 2)) && !div_prev;
      if (wd == T_TIMEOUT - 1 && will_tick) bus.ready_S = 1'b1;
      step();
      if (tick_now && pre != 3'd0 && pre != 3'd7) wd++;
      if (bus.stare_semafor == 3'd7 || bus.stare_semafor == 3'd0) break;
    end
    chk("tie_ticks", wd, T_TIMEOUT);
    chk("tie_stare", bus.stare_semafor, 3'd7);
    chk("tie_err", bus.eroare, 1'b1);
    $display("watchdog/handshake tie after %0d ticks -> state %0d err %0d", wd, bus.stare_semafor, bus.eroare);

    // Stuck-high ready in V: fault on the T_TIMEOUT-th tick, sticky until reset.
    do_reset();
    run_clear(3'd1);
    exp_phase = 3'd1;
    advance();
    advance();
    bus.ready_V = 1'b1;
    wd = 0;
    for (int i = 0; i < 2000; i++) begin
      pre = bus.stare_semafor;
      step();
      if (tick_now && pre == 3'd3) wd++;
      if (bus.stare_semafor != 3'd3) break;
    end
    chk("wd_ticks", wd, T_TIMEOUT);
    chk("wd_stare", bus.stare_semafor, 3'd7);
    chk("wd_err", bus.eroare, 1'b1);
    $display("watchdog in V after %0d ticks -> state %0d err %0d", wd, bus.stare_semafor, bus.eroare);
    cur_sel = 3'd0;
    steps(5 * TICK_P);
    chk("fault_sticky", bus.stare_semafor, 3'd7);
    chk("fault_err_sticky", bus.eroare, 1'b1);

    do_reset();
    chk("final_rst_stare", bus.stare_semafor, 3'd0);
    chk("final_rst_err", bus.eroare, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
